uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, SHALL set the number of requesters sharing one UART transmitter.
REQ-002 Parameter PAYLOAD_BITS, default 8, SHALL set the byte width per requester.
REQ-003 Parameter BUSY_TIMEOUT, default 16, SHALL set the cycles allowed after t_enable for the transmitter to assert busy.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 reset  input  1  SHALL be the synchronous, active-low reset.
REQ-006 req  input  N_REQ  SHALL be the per-requester level "byte pending" flag.
REQ-007 req_data  input  N_REQ*PAYLOAD_BITS  SHALL carry requester i's byte in bits [i*PAYLOAD_BITS +: PAYLOAD_BITS].
REQ-008 req_ack  output  N_REQ  SHALL be a one-cycle pulse: requester i's byte was captured.
REQ-009 parallel_in  output  PAYLOAD_BITS  SHALL be the byte driven to the transmitter.
REQ-010 t_enable  output  1  SHALL be the one-cycle transmit-start pulse to the transmitter.
REQ-011 busy  input  1  SHALL be the transmitter busy flag.
REQ-012 active_id  output  clog2(N_REQ)  SHALL identify the requester currently granted.
REQ-013 arb_busy  output  1  SHALL be high whenever the FSM is not in IDLE.
REQ-014 timeout_err  output  1  SHALL be a sticky flag: busy failed to assert within BUSY_TIMEOUT.

Function
REQ-015 FSM states SHALL be IDLE, START, WAIT_BUSY, WAIT_DONE.
REQ-016 IDLE: when req!=0 and busy==0 at an edge, SHALL select the first asserted requester searching ptr+1, ptr+2, ... mod N_REQ, where ptr is the last granted index.
REQ-017 On that edge: parallel_in<=selected byte, active_id<=i, ptr<=i, req_ack[i]<=1 for exactly one cycle, state->START.
REQ-018 IDLE with busy==1 SHALL NOT grant, regardless of req.
REQ-019 START: t_enable SHALL be high for exactly this one cycle; state->WAIT_BUSY; timeout counter cleared.
REQ-020 WAIT_BUSY: busy==1 -> WAIT_DONE; otherwise counter increments; if it reaches BUSY_TIMEOUT-1 with busy still 0, timeout_err<=1 and state->IDLE.
REQ-021 WAIT_DONE: busy==0 -> IDLE; else hold.
REQ-022 parallel_in and active_id SHALL stay stable from the grant edge until the next grant.
REQ-023 Latency: req seen at edge N -> req_ack high in cycle N+1, t_enable high in cycle N+2.
REQ-024 Back-to-back: at least one IDLE cycle SHALL separate the busy falling edge from the next req_ack.
REQ-025 A req deasserted before the evaluating edge SHALL NOT be granted; req changes after the grant SHALL NOT affect the captured byte.
REQ-026 A requester holding req continuously SHALL be granted at most once per N_REQ grants while others request (round-robin fairness).
REQ-027 timeout_err SHALL clear only on reset; arbitration SHALL continue normally after it is set.

Reset
REQ-028 reset==0 at an edge SHALL force: state IDLE, req_ack=0, t_enable=0, parallel_in=0, active_id=0, arb_busy=0, timeout_err=0, ptr=N_REQ-1 (requester 0 first priority).
REQ-029 Reset asserted mid-transfer SHALL take effect at that edge, dropping t_enable and arb_busy with no further ack.

Verification
REQ-030 Single: req=0001, req_data[7:0]=0xA5, transmitter model busy 3 cycles after t_enable for 10 cycles -> req_ack=0001 one cycle, t_enable one cycle later, parallel_in=0xA5, arb_busy low after busy falls.
REQ-031 Fairness: req=1111 held, bytes 0x10/0x21/0x32/0x43 -> grant order 0,1,2,3,0; each parallel_in matches its requester.
REQ-032 Timeout: busy tied 0, req=0010 -> t_enable pulses, 16 cycles later timeout_err=1, FSM IDLE, next grant still occurs.
REQ-033 Busy blocking: busy=1 in IDLE, req=0100 -> no req_ack until busy=0, then grant to 2.
REQ-034 Reset mid-op: reset=0 during WAIT_DONE -> next cycle all outputs 0, ptr reset; with req=1000 after release, requester 3 granted.
REQ-035 Loopback: instantiate with the team transmitter and receiver, serial_out looped to serial_in -> receiver parallel_out sequence equals granted byte sequence.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Shares one UART transmitter between N_REQ requesters using round-robin
// arbitration. A granted byte is latched onto parallel_in and a one-cycle
// t_enable pulse starts the transmitter. The arbiter then waits for the
// transmitter to raise busy, with a bounded wait, and for busy to fall
// again before it grants the next requester.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous active-low reset
//   req          per-requester byte-pending level flags
//   req_data     requester i byte at [i*PAYLOAD_BITS +: PAYLOAD_BITS]
//   req_ack      one-cycle pulse, requester i byte captured
//   parallel_in  byte presented to the transmitter
//   t_enable     one-cycle transmit-start pulse
//   busy         transmitter busy flag
//   active_id    index of the requester currently granted
//   arb_busy     high whenever the FSM is not in IDLE
//   timeout_err  sticky, transmitter never raised busy after t_enable
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for a pending request while the transmitter is idle
// START     | byte captured, ack pulsing; t_enable is issued on exit
// WAIT_BUSY | waiting for busy to rise, bounded by BUSY_TIMEOUT cycles
// WAIT_DONE | transmitter is sending, waiting for busy to fall
module uart_tx_arbiter #(
  parameter int N_REQ        = 4,
  parameter int PAYLOAD_BITS = 8,
  parameter int BUSY_TIMEOUT = 16,
  localparam int ID_W        = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*PAYLOAD_BITS-1:0] req_data,
  output logic [N_REQ-1:0]          req_ack,
  output logic [PAYLOAD_BITS-1:0]   parallel_in,
  output logic                      t_enable,
  input  logic                      busy,
  output logic [ID_W-1:0]           active_id,
  output logic                      arb_busy,
  output logic                      timeout_err
);

  localparam int CNT_W = $clog2(BUSY_TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(BUSY_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} state_t;

  state_t           state, state_nxt;
  logic [ID_W-1:0]  ptr;
  logic [ID_W-1:0]  sel;
  logic             sel_vld;
  logic [CNT_W-1:0] cnt;
  logic             grant;
  logic             cnt_clr;
  logic             cnt_inc;
  logic             to_set;

  // Round-robin search starting just after the last granted index. The
  // loop runs from the farthest offset down so the nearest hit wins.
  always_comb begin
    int idx;
    idx     = 0;
    sel     = '0;
    sel_vld = 1'b0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (req[idx]) begin
        sel     = ID_W'(idx);
        sel_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    to_set    = 1'b0;
    case (state)
      IDLE: begin
        if (sel_vld && !busy) begin
          grant     = 1'b1;
          state_nxt = START;
        end
      end
      START: begin
        cnt_clr   = 1'b1;
        state_nxt = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        // busy wins over the terminal count on the same edge
        if (busy) begin
          state_nxt = WAIT_DONE;
        end else if (cnt == CNT_TC) begin
          to_set    = 1'b1;
          state_nxt = IDLE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!busy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      req_ack     <= '0;
      t_enable    <= 1'b0;
      parallel_in <= '0;
      active_id   <= '0;
      ptr         <= ID_W'(N_REQ - 1);
      cnt         <= '0;
      timeout_err <= 1'b0;
    end else begin
      state    <= state_nxt;
      req_ack  <= '0;
      // registered from START so the pulse lands one cycle after the ack
      t_enable <= (state == START);
      if (grant) begin
        parallel_in <= req_data[sel*PAYLOAD_BITS +: PAYLOAD_BITS];
        active_id   <= sel;
        ptr         <= sel;
        req_ack     <= N_REQ'(1) << sel;
      end
      if (cnt_clr) begin
        cnt <= '0;
      end else if (cnt_inc) begin
        cnt <= cnt + 1'b1;
      end
      if (to_set) timeout_err <= 1'b1;
    end
  end

  assign arb_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: a behavioural UART transmitter (busy rises 3
// cycles after t_enable, holds 10 cycles while shifting a 10-bit frame)
// looped into a behavioural receiver. Expected grants and expected
// received bytes are queued by the stimulus; monitors pop and compare.
module tb_uart_tx_arbiter;
  localparam int N = 4;
  localparam int W = 8;
  localparam int TO = 16;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0]   req_ack;
  logic [W-1:0]   parallel_in;
  logic           t_enable;
  logic           busy;
  logic [1:0]     active_id;
  logic           arb_busy;
  logic           timeout_err;

  logic tx_busy = 1'b0;
  logic busy_force = 1'b0;
  logic tx_mute = 1'b0;
  logic serial = 1'b1;
  int   tx_cnt = 0;

  assign busy = tx_busy | busy_force;

  uart_tx_arbiter #(.N_REQ(N), .PAYLOAD_BITS(W), .BUSY_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data),
    .req_ack(req_ack), .parallel_in(parallel_in), .t_enable(t_enable),
    .busy(busy), .active_id(active_id), .arb_busy(arb_busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         id;
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] rx_q[$];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req_v);
    end
  endtask

  task automatic expect_grant(input int id, input logic [7:0] data, input bit on_wire);
    exp_t e;
    e.id = id;
    e.data = data;
    exp_q.push_back(e);
    if (on_wire) rx_q.push_back(data);
  endtask

  // transmitter model
  initial begin
    logic [9:0] shreg;
    shreg = '1;
    forever begin
      @(posedge clk);
      if (!reset) begin
        tx_busy <= 1'b0;
        serial  <= 1'b1;
        tx_cnt  = 0;
      end else if (tx_cnt == 0) begin
        if (t_enable === 1'b1 && !tx_mute) begin
          shreg  = {1'b1, parallel_in, 1'b0};
          tx_cnt = 1;
        end
      end else begin
        if (tx_cnt == 3) tx_busy <= 1'b1;
        if (tx_cnt >= 3 && tx_cnt <= 12) serial <= shreg[tx_cnt-3];
        if (tx_cnt == 13) begin
          tx_busy <= 1'b0;
          tx_cnt  = 0;
        end else begin
          tx_cnt++;
        end
      end
    end
  end

  // receiver model, samples mid-bit on the falling edge
  initial begin
    int rx_cnt;
    logic [7:0] rx_byte;
    rx_cnt = 0;
    rx_byte = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        rx_cnt = 0;
      end else if (rx_cnt == 0) begin
        if (serial == 1'b0) rx_cnt = 1;
      end else if (rx_cnt <= 8) begin
        rx_byte[rx_cnt-1] = serial;
        rx_cnt++;
      end else begin
        chk("rx_stop_bit", serial, 1);
        if (rx_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rx_unexpected actual=%0h required=none", rx_byte);
        end else begin
          chk("rx_byte", rx_byte, rx_q.pop_front());
        end
        rx_cnt = 0;
      end
    end
  end

  // grant monitor
  initial begin
    bit pend_ten;
    exp_t e;
    pend_ten = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        pend_ten = 1'b0;
      end else if (req_ack != '0) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL ack_unexpected actual=%b required=none", req_ack);
        end else begin
          e = exp_q.pop_front();
          chk("ack_onehot", req_ack, 32'd1 << e.id);
          chk("grant_id", active_id, e.id);
          chk("grant_byte", parallel_in, e.data);
          chk("t_enable_in_ack_cycle", t_enable, 0);
        end
        pend_ten = 1'b1;
      end else if (pend_ten) begin
        chk("t_enable_after_ack", t_enable, 1);
        pend_ten = 1'b0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_ack(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      tick(1);
      seen = (req_ack != '0);
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s_bound actual=no_ack required=ack", name);
    end
  endtask

  task automatic wait_idle(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      tick(1);
      done = (arb_busy == 1'b0 && tx_cnt == 0 && req_ack == '0);
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s_bound actual=busy required=idle", name);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_req_ack"}, req_ack, 0);
    chk({tag, "_t_enable"}, t_enable, 0);
    chk({tag, "_parallel_in"}, parallel_in, 0);
    chk({tag, "_active_id"}, active_id, 0);
    chk({tag, "_arb_busy"}, arb_busy, 0);
    chk({tag, "_timeout_err"}, timeout_err, 0);
  endtask

  initial begin
    bit seen;
    // reset state
    reset = 1'b0;
    tick(2);
    check_zero_outputs("reset");
    reset = 1'b1;
    tick(1);

    // a request withdrawn before the edge is not granted
    req = 4'b0001;
    #2;
    req = 4'b0000;
    tick(3);
    chk("withdrawn_no_ack", req_ack, 0);
    chk("withdrawn_idle", arb_busy, 0);

    // single transfer
    req_data[7:0] = 8'hA5;
    expect_grant(0, 8'hA5, 1'b1);
    req = 4'b0001;
    tick(1);
    chk("single_ack_latency", req_ack, 4'b0001);
    chk("single_arb_busy", arb_busy, 1);
    req = 4'b0000;
    req_data[7:0] = 8'hFF;
    wait_idle("single_idle");
    chk("single_byte_held", parallel_in, 8'hA5);
    chk("single_busy_low", busy, 0);

    // fairness from a fresh reset: order 0,1,2,3,0
    reset = 1'b0;
    tick(1);
    reset = 1'b1;
    req_data = 32'h43322110;
    expect_grant(0, 8'h10, 1'b1);
    expect_grant(1, 8'h21, 1'b1);
    expect_grant(2, 8'h32, 1'b1);
    expect_grant(3, 8'h43, 1'b1);
    expect_grant(0, 8'h10, 1'b1);
    req = 4'b1111;
    for (int g = 0; g < 5; g++) wait_ack("fair_ack");
    req = 4'b0000;
    wait_idle("fair_idle");

    // timeout: transmitter ignores t_enable
    tx_mute = 1'b1;
    req_data[15:8] = 8'h5C;
    expect_grant(1, 8'h5C, 1'b0);
    req = 4'b0010;
    wait_ack("timeout_ack");
    req = 4'b0000;
    tick(1);
    chk("timeout_t_enable", t_enable, 1);
    tick(15);
    chk("timeout_not_yet", timeout_err, 0);
    chk("timeout_still_waiting", arb_busy, 1);
    tick(1);
    chk("timeout_err_set", timeout_err, 1);
    chk("timeout_back_idle", arb_busy, 0);
    tx_mute = 1'b0;

    // busy blocks granting in IDLE, then grant to 2 once busy drops
    busy_force = 1'b1;
    req_data[23:16] = 8'h7E;
    expect_grant(2, 8'h7E, 1'b1);
    req = 4'b0100;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      chk("blocked_no_ack", req_ack, 0);
    end
    busy_force = 1'b0;
    wait_ack("blocked_ack");
    req = 4'b0000;
    wait_idle("blocked_idle");
    chk("timeout_sticky", timeout_err, 1);

    // reset during WAIT_DONE
    req_data[7:0] = 8'h3C;
    req_data[31:24] = 8'h96;
    expect_grant(0, 8'h3C, 1'b1);
    req = 4'b0001;
    wait_ack("midop_ack");
    req = 4'b0000;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      tick(1);
      seen = (busy == 1'b1 && arb_busy == 1'b1);
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL midop_busy_bound actual=no_busy required=busy");
    end
    tick(2);
    reset = 1'b0;
    void'(rx_q.pop_back());
    tick(1);
    check_zero_outputs("midop_reset");
    reset = 1'b1;
    // with the pointer back at 3, requester 0 comes before 3
    expect_grant(0, 8'h3C, 1'b1);
    expect_grant(3, 8'h96, 1'b1);
    req = 4'b1001;
    wait_ack("post_reset_ack0");
    req = 4'b1000;
    wait_ack("post_reset_ack3");
    req = 4'b0000;
    wait_idle("post_reset_idle");

    tick(5);
    chk("grant_queue_drained", exp_q.size(), 0);
    chk("rx_queue_drained", rx_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit actual=running required=finished");
    $fatal(1, "time limit");
  end

endmodule
